// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and default timing.
// PARITY is always declared; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Even parity over a zero-extended data word.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the UART transmitter: strobes on the last clock of each bit.
// It never wraps on its own; the owner clears it at every bit boundary.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic bit_strobe
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_strobe = enable && (count_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept, timer_en, timer_clear, bit_strobe;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign accept      = tx_start && ((state_q == IDLE) || (state_q == DONE));
  assign timer_en    = (state_q != IDLE) && (state_q != DONE);
  assign timer_clear = !timer_en || bit_strobe;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (timer_clear),
    .enable    (timer_en),
    .bit_strobe(bit_strobe)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      // DONE accepts a new request exactly like IDLE for gapless frames.
      IDLE, DONE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(8'(tx_data));
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_strobe) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_strobe) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_strobe) begin
          state_d = DONE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are a registered decode of the current state, so they trail it by one clock.
  always_comb begin
    serial_d = IDLE_LEVEL;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE:  serial_d = IDLE_LEVEL;
      START: begin
        serial_d = START_LEVEL;
        busy_d   = 1'b1;
      end
      DATA: begin
        serial_d = shift_q[0];
        busy_d   = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = parity_q;
        busy_d   = 1'b1;
      end
`endif
      STOP: begin
        serial_d = STOP_LEVEL;
        busy_d   = 1'b1;
      end
      DONE: begin
        serial_d = STOP_LEVEL;
        done_d   = 1'b1;
      end
      default: serial_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
